delta_calc_axil_slave: RTL and testbench

AXI4-Lite responder holding the delta_calc control/status register bank on the S00_AXI port. It accepts single-beat writes and reads from the system interconnect master, or from the lite master BFM in block-design benches, and exposes the four 32-bit registers to the delta_calc datapath. Address and data channels are decoupled, and byte strobes are honoured. Responses are registered and held until accepted.

---
 rtl/delta_calc_pkg.sv | 28 ++
 rtl/delta_calc_strb_merge.sv | 19 +
 rtl/delta_calc_axil_slave.sv | 183 ++++++++++++++++++
 tb/tb_delta_calc_axil_slave.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/delta_calc_pkg.sv
// Shared constants and FSM state types for the delta_calc AXI4-Lite register bank.
package delta_calc_pkg;

  localparam int NUM_REGS = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CFG  = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam logic [31:0] RD_ERR_FILL = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/delta_calc_strb_merge.sv
// Byte-strobe merge: replaces the bytes of old_word selected by wstrb with the
// matching bytes of wdata.
module delta_calc_strb_merge #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   old_word,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  output logic [WIDTH-1:0]   new_word
);

  always_comb begin
    new_word = old_word;
    for (int k = 0; k < WIDTH / 8; k++) begin
      if (wstrb[k]) new_word[8*k +: 8] = wdata[8*k +: 8];
    end
  end

endmodule

// File: rtl/delta_calc_axil_slave.sv
// AXI4-Lite responder for the four delta_calc control/status registers.
// Optional out-of-range SLVERR decoding is enabled by DELTA_CALC_AXIL_SLVERR_EN.
module delta_calc_axil_slave
  import delta_calc_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                                       ACLK,
  input  logic                                       ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
  input  logic [2:0]                                 S_AXI_AWPROT,
  input  logic                                       S_AXI_AWVALID,
  output logic                                       S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
  input  logic                                       S_AXI_WVALID,
  output logic                                       S_AXI_WREADY,
  output logic [1:0]                                 S_AXI_BRESP,
  output logic                                       S_AXI_BVALID,
  input  logic                                       S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
  input  logic [2:0]                                 S_AXI_ARPROT,
  input  logic                                       S_AXI_ARVALID,
  output logic                                       S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
  output logic [1:0]                                 S_AXI_RRESP,
  output logic                                       S_AXI_RVALID,
  input  logic                                       S_AXI_RREADY,
  output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                        reg_wr_pulse
);

  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic                          rst_done;
  logic                          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                          wr_commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q, wr_data, merged;
  logic [SW-1:0]                 w_strb_q, wr_strb;
  logic [1:0]                    wr_idx, rd_idx;
  logic                          wr_ok, rd_ok;
  logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs;
  logic                          unused_bits;

  // rst_done keeps every READY low until the cycle after reset is released
  assign S_AXI_AWREADY = rst_done && (wr_state == W_IDLE || wr_state == W_HAVE_D);
  assign S_AXI_WREADY  = rst_done && (wr_state == W_IDLE || wr_state == W_HAVE_A);
  assign S_AXI_BVALID  = (wr_state == W_RESP);
  assign S_AXI_ARREADY = rst_done && (rd_state == R_IDLE);
  assign S_AXI_RVALID  = (rd_state == R_RESP);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign b_hs  = S_AXI_BVALID  && S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID  && S_AXI_RREADY;

  assign wr_idx = wr_addr[3:2];
  assign rd_idx = S_AXI_ARADDR[3:2];

`ifdef DELTA_CALC_AXIL_SLVERR_EN
  assign wr_ok = (wr_addr[C_S_AXI_ADDR_WIDTH-1:4] == '0);
  assign rd_ok = (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4] == '0);
`else
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr, S_AXI_ARADDR};

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  // The commit uses whichever half was held plus the half arriving this cycle
  always_comb begin
    wr_state_nxt = wr_state;
    wr_commit    = 1'b0;
    wr_addr      = S_AXI_AWADDR;
    wr_data      = S_AXI_WDATA;
    wr_strb      = S_AXI_WSTRB;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit    = 1'b1;
          wr_state_nxt = W_RESP;
        end else if (aw_hs) begin
          wr_state_nxt = W_HAVE_A;
        end else if (w_hs) begin
          wr_state_nxt = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        wr_addr = aw_addr_q;
        if (w_hs) begin
          wr_commit    = 1'b1;
          wr_state_nxt = W_RESP;
        end
      end
      W_HAVE_D: begin
        wr_data = w_data_q;
        wr_strb = w_strb_q;
        if (aw_hs) begin
          wr_commit    = 1'b1;
          wr_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_nxt = R_RESP;
      R_RESP:  if (r_hs)  rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  delta_calc_strb_merge #(
    .WIDTH(C_S_AXI_DATA_WIDTH)
  ) u_strb_merge (
    .old_word(regs[wr_idx]),
    .wdata   (wr_data),
    .wstrb   (wr_strb),
    .new_word(merged)
  );

  // Reads sample regs before this edge's write lands, so a colliding read sees the old value
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rst_done     <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      regs         <= '0;
      reg_wr_pulse <= '0;
      S_AXI_BRESP  <= RESP_OKAY;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else begin
      rst_done     <= 1'b1;
      reg_wr_pulse <= '0;
      if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (wr_commit) begin
        S_AXI_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          regs[wr_idx]         <= merged;
          reg_wr_pulse[wr_idx] <= 1'b1;
        end
      end
      if (ar_hs) begin
        S_AXI_RDATA <= rd_ok ? regs[rd_idx] : RD_ERR_FILL;
        S_AXI_RRESP <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign reg_out[REG_CTRL] = regs[REG_CTRL];
  assign reg_out[REG_CFG]  = regs[REG_CFG];
  assign reg_out[REG_DATA] = regs[REG_DATA];
  assign reg_out[REG_STAT] = regs[REG_STAT];

endmodule

// File: tb/tb_delta_calc_axil_slave.sv
// Directed self-checking bench for delta_calc_axil_slave; expected values are hand-computed.
module tb_delta_calc_axil_slave;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESETN;
  logic [5:0]  tb_AWADDR;
  logic [2:0]  tb_AWPROT;
  logic        tb_AWVALID;
  logic        tb_AWREADY;
  logic [31:0] tb_WDATA;
  logic [3:0]  tb_WSTRB;
  logic        tb_WVALID;
  logic        tb_WREADY;
  logic [1:0]  tb_BRESP;
  logic        tb_BVALID;
  logic        tb_BREADY;
  logic [5:0]  tb_ARADDR;
  logic [2:0]  tb_ARPROT;
  logic        tb_ARVALID;
  logic        tb_ARREADY;
  logic [31:0] tb_RDATA;
  logic [1:0]  tb_RRESP;
  logic        tb_RVALID;
  logic        tb_RREADY;
  logic [3:0][31:0] tb_reg_out;
  logic [3:0]  tb_reg_wr_pulse;

  int total_checks = 0;
  int bad_checks   = 0;

  always #5 tb_ACLK = ~tb_ACLK;

  delta_calc_axil_slave dut (
    .ACLK         (tb_ACLK),
    .ARESETN      (tb_ARESETN),
    .S_AXI_AWADDR (tb_AWADDR),
    .S_AXI_AWPROT (tb_AWPROT),
    .S_AXI_AWVALID(tb_AWVALID),
    .S_AXI_AWREADY(tb_AWREADY),
    .S_AXI_WDATA  (tb_WDATA),
    .S_AXI_WSTRB  (tb_WSTRB),
    .S_AXI_WVALID (tb_WVALID),
    .S_AXI_WREADY (tb_WREADY),
    .S_AXI_BRESP  (tb_BRESP),
    .S_AXI_BVALID (tb_BVALID),
    .S_AXI_BREADY (tb_BREADY),
    .S_AXI_ARADDR (tb_ARADDR),
    .S_AXI_ARPROT (tb_ARPROT),
    .S_AXI_ARVALID(tb_ARVALID),
    .S_AXI_ARREADY(tb_ARREADY),
    .S_AXI_RDATA  (tb_RDATA),
    .S_AXI_RRESP  (tb_RRESP),
    .S_AXI_RVALID (tb_RVALID),
    .S_AXI_RREADY (tb_RREADY),
    .reg_out      (tb_reg_out),
    .reg_wr_pulse (tb_reg_wr_pulse)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic finish_b();
    tb_BREADY = 1'b1;
    step();
    tb_BREADY = 1'b0;
  endtask

  task automatic finish_r();
    tb_RREADY = 1'b1;
    step();
    tb_RREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [3:0] pulse);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int n = 0;
    tb_AWADDR = addr; tb_AWVALID = 1'b1;
    tb_WDATA = data; tb_WSTRB = strb; tb_WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_fire = tb_AWVALID && tb_AWREADY;
      w_fire  = tb_WVALID && tb_WREADY;
      step();
      n++;
      if (aw_fire) begin aw_done = 1; tb_AWVALID = 1'b0; end
      if (w_fire)  begin w_done = 1;  tb_WVALID = 1'b0; end
    end
    tb_AWVALID = 1'b0; tb_WVALID = 1'b0;
    check_output("wr_accept", 32'(aw_done && w_done), 32'd1);
    pulse = tb_reg_wr_pulse;
    n = 0;
    while (!tb_BVALID && n < 20) begin step(); n++; end
    check_output("bvalid_seen", 32'(tb_BVALID), 32'd1);
    resp = tb_BRESP;
    finish_b();
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    tb_ARADDR = addr; tb_ARVALID = 1'b1;
    while (!tb_ARREADY && n < 20) begin step(); n++; end
    step();
    tb_ARVALID = 1'b0;
    n = 0;
    while (!tb_RVALID && n < 20) begin step(); n++; end
    check_output("rvalid_seen", 32'(tb_RVALID), 32'd1);
    data = tb_RDATA;
    resp = tb_RRESP;
    finish_r();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] wr_vals [4];
    logic [31:0] rd;
    logic [1:0]  resp;
    logic [3:0]  pulse;
    bit          stable;

    wr_vals[0] = 32'h0101FFFF; wr_vals[1] = 32'habcd0001;
    wr_vals[2] = 32'hdead0011; wr_vals[3] = 32'hbeef0011;

    tb_ARESETN = 1'b0;
    tb_AWADDR = '0; tb_AWPROT = '0; tb_AWVALID = 1'b0;
    tb_WDATA = '0; tb_WSTRB = '0; tb_WVALID = 1'b0; tb_BREADY = 1'b0;
    tb_ARADDR = '0; tb_ARPROT = '0; tb_ARVALID = 1'b0; tb_RREADY = 1'b0;
    repeat (3) step();

    check_output("rst_readys", {29'd0, tb_AWREADY, tb_WREADY, tb_ARREADY}, 32'd0);
    check_output("rst_valids", {30'd0, tb_BVALID, tb_RVALID}, 32'd0);
    check_output("rst_regs", 32'(|tb_reg_out), 32'd0);
    check_output("rst_rdata", tb_RDATA, 32'd0);
    check_output("rst_resps", {28'd0, tb_BRESP, tb_RRESP}, 32'd0);
    check_output("rst_pulse", 32'(tb_reg_wr_pulse), 32'd0);
    tb_ARESETN = 1'b1;
    check_output("ready_before_release", {29'd0, tb_AWREADY, tb_WREADY, tb_ARREADY}, 32'd0);
    step();
    check_output("ready_after_release", {29'd0, tb_AWREADY, tb_WREADY, tb_ARREADY}, 32'd7);

    // Full-word writes and readback of every register
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(4 * i), wr_vals[i], 4'hF, resp, pulse);
      check_output($sformatf("wr%0d_bresp", i), 32'(resp), 32'd0);
      check_output($sformatf("wr%0d_pulse", i), 32'(pulse), 32'(4'b0001 << i));
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(4 * i), rd, resp);
      check_output($sformatf("rd%0d_data", i), rd, wr_vals[i]);
      check_output($sformatf("rd%0d_rresp", i), 32'(resp), 32'd0);
      check_output($sformatf("reg_out%0d", i), tb_reg_out[i], wr_vals[i]);
    end

    // W three cycles ahead of AW
    tb_WDATA = 32'h12345678; tb_WSTRB = 4'hF; tb_WVALID = 1'b1;
    step();
    tb_WVALID = 1'b0;
    check_output("have_d_readys", {30'd0, tb_AWREADY, tb_WREADY}, 32'd2);
    repeat (2) step();
    check_output("have_d_no_commit", {tb_BVALID, 27'd0, tb_reg_wr_pulse}, 32'd0);
    check_output("have_d_reg_kept", tb_reg_out[2], 32'hdead0011);
    tb_AWADDR = 6'h08; tb_AWVALID = 1'b1;
    step();
    tb_AWVALID = 1'b0;
    check_output("wfirst_bvalid", 32'(tb_BVALID), 32'd1);
    check_output("wfirst_pulse", 32'(tb_reg_wr_pulse), 32'b0100);
    check_output("wfirst_reg", tb_reg_out[2], 32'h12345678);
    step();
    check_output("wfirst_once", {tb_BVALID, 27'd0, tb_reg_wr_pulse}, 32'h80000000);
    finish_b();

    // AW three cycles ahead of W
    tb_AWADDR = 6'h0C; tb_AWVALID = 1'b1;
    step();
    tb_AWVALID = 1'b0;
    check_output("have_a_readys", {30'd0, tb_AWREADY, tb_WREADY}, 32'd1);
    repeat (2) step();
    check_output("have_a_no_commit", {tb_BVALID, 27'd0, tb_reg_wr_pulse}, 32'd0);
    tb_WDATA = 32'h0BADF00D; tb_WSTRB = 4'hF; tb_WVALID = 1'b1;
    step();
    tb_WVALID = 1'b0;
    check_output("afirst_bvalid", 32'(tb_BVALID), 32'd1);
    check_output("afirst_pulse", 32'(tb_reg_wr_pulse), 32'b1000);
    check_output("afirst_reg", tb_reg_out[3], 32'h0BADF00D);
    step();
    check_output("afirst_once", {tb_BVALID, 27'd0, tb_reg_wr_pulse}, 32'h80000000);
    finish_b();

    // Partial strobe merge on register 1
    axi_write(6'h04, 32'hFFFFFFFF, 4'hF, resp, pulse);
    axi_write(6'h04, 32'h00000000, 4'b0101, resp, pulse);
    axi_read(6'h04, rd, resp);
    check_output("strb_merge", rd, 32'hFF00FF00);

    // Backpressure on both response channels
    tb_AWADDR = 6'h00; tb_WDATA = 32'hCAFE0001; tb_WSTRB = 4'hF;
    tb_AWVALID = 1'b1; tb_WVALID = 1'b1;
    step();
    tb_AWVALID = 1'b0; tb_WVALID = 1'b0;
    tb_ARADDR = 6'h00; tb_ARVALID = 1'b1;
    step();
    tb_ARVALID = 1'b0;
    stable = 1;
    for (int c = 0; c < 5; c++) begin
      if (!(tb_BVALID && tb_BRESP == 2'b00 && tb_RVALID && tb_RDATA == 32'hCAFE0001 &&
            tb_RRESP == 2'b00 && !tb_AWREADY && !tb_WREADY && !tb_ARREADY)) stable = 0;
      step();
    end
    check_output("backpressure_stable", 32'(stable), 32'd1);
    tb_BREADY = 1'b1; tb_RREADY = 1'b1;
    step();
    tb_BREADY = 1'b0; tb_RREADY = 1'b0;
    check_output("bp_released", {27'd0, tb_BVALID, tb_RVALID, tb_AWREADY, tb_WREADY, tb_ARREADY},
                 32'b00111);

    // Read and write of the same register in the same cycle
    tb_AWADDR = 6'h00; tb_WDATA = 32'h11112222; tb_WSTRB = 4'hF; tb_ARADDR = 6'h00;
    tb_AWVALID = 1'b1; tb_WVALID = 1'b1; tb_ARVALID = 1'b1;
    step();
    tb_AWVALID = 1'b0; tb_WVALID = 1'b0; tb_ARVALID = 1'b0;
    check_output("collide_rdata", tb_RDATA, 32'hCAFE0001);
    check_output("collide_reg", tb_reg_out[0], 32'h11112222);
    finish_b();
    finish_r();

    // Address 0x14: aliases register 1 or errors, depending on build
    axi_read(6'h14, rd, resp);
`ifdef DELTA_CALC_AXIL_SLVERR_EN
    check_output("oor_rdata", rd, 32'hDEADBEEF);
    check_output("oor_rresp", 32'(resp), 32'd2);
`else
    check_output("alias_rdata", rd, 32'hFF00FF00);
    check_output("alias_rresp", 32'(resp), 32'd0);
`endif

    // Reset pulse while a write response is pending
    tb_AWADDR = 6'h08; tb_WDATA = 32'h55AA55AA; tb_WSTRB = 4'hF;
    tb_AWVALID = 1'b1; tb_WVALID = 1'b1;
    step();
    tb_AWVALID = 1'b0; tb_WVALID = 1'b0;
    check_output("pre_rst_bvalid", 32'(tb_BVALID), 32'd1);
    tb_ARESETN = 1'b0;
    step();
    tb_ARESETN = 1'b1;
    check_output("mid_rst_bvalid", 32'(tb_BVALID), 32'd0);
    check_output("mid_rst_regs", 32'(|tb_reg_out), 32'd0);
    check_output("mid_rst_readys", {29'd0, tb_AWREADY, tb_WREADY, tb_ARREADY}, 32'd0);
    step();
    check_output("post_rst_readys", {29'd0, tb_AWREADY, tb_WREADY, tb_ARREADY}, 32'd7);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
